// File: rtl/fp_lzd_normalizer_if.sv
// Handshake and data bundle for the leading-one normalizer.
// The master side produces words and consumes results; the slave side is the normalizer.
interface fp_lzd_normalizer_if #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned EXP_W = 8,
  parameter int unsigned POS_W = $clog2(WIDTH)
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] mant_i;
  logic [EXP_W-1:0] exp_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] mant_o;
  logic [EXP_W-1:0] exp_o;
  logic [POS_W-1:0] pos_o;
  logic [POS_W-1:0] shift_o;
  logic             zero_o;
  logic             unf_o;

  modport master (
    output in_valid_i, mant_i, exp_i, out_ready_i,
    input  in_ready_o, out_valid_o, mant_o, exp_o, pos_o, shift_o, zero_o, unf_o
  );

  modport slave (
    input  in_valid_i, mant_i, exp_i, out_ready_i,
    output in_ready_o, out_valid_o, mant_o, exp_o, pos_o, shift_o, zero_o, unf_o
  );
endinterface

// File: rtl/fp_lzd_normalizer.sv
// Two-stage leading-one detector and mantissa normalizer with exponent clamping.
// Stage 1 encodes the highest set bit; stage 2 shifts and adjusts the exponent.
// The clamp limits the shift to the exponent, so the exponent never wraps below zero
// and the result becomes a denormal instead.
module fp_lzd_normalizer #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned EXP_W = 8,
  parameter int unsigned POS_W = $clog2(WIDTH)
) (
  input logic                clk_i,
  input logic                rst_i,
  fp_lzd_normalizer_if.slave bus
);

  localparam int unsigned CMP_W = (EXP_W > POS_W) ? EXP_W : POS_W;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_mant;
  logic [EXP_W-1:0] s1_exp;
  logic [POS_W-1:0] s1_pos;
  logic [POS_W-1:0] s1_req;
  logic             s1_zero;

  logic             s2_adv_c;
  logic             s1_adv_c;
  logic             in_fire_c;
  logic [POS_W-1:0] pos_c;
  logic             zero_c;
  logic [POS_W-1:0] req_c;

  logic             clamp_c;
  logic [POS_W-1:0] shift_c;
  logic [EXP_W-1:0] exp_c;
  logic [WIDTH-1:0] mant_c;
  logic [POS_W-1:0] pos2_c;

  // Pipeline advance: a stage moves when the stage after it is empty or draining.
  always_comb begin
    s2_adv_c  = ~bus.out_valid_o | bus.out_ready_i;
    s1_adv_c  = ~s1_valid | s2_adv_c;
    in_fire_c = bus.in_valid_i & bus.in_ready_o;
  end

  assign bus.in_ready_o = s1_adv_c & ~rst_i;

  // MSB-priority encode: the last set bit seen while scanning upward wins.
  always_comb begin
    pos_c  = '0;
    zero_c = 1'b1;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (bus.mant_i[i]) begin
        pos_c  = POS_W'(i);
        zero_c = 1'b0;
      end
    end
    req_c = POS_W'(WIDTH - 1) - pos_c;
  end

  // Shift stage: full normalization, or a shift clamped to the exponent on underflow.
  always_comb begin
    clamp_c = CMP_W'(s1_req) > CMP_W'(s1_exp);
    shift_c = clamp_c ? POS_W'(s1_exp) : s1_req;
    exp_c   = clamp_c ? '0 : s1_exp - EXP_W'(s1_req);
    mant_c  = s1_mant << shift_c;
    pos2_c  = s1_pos;
    if (s1_zero) begin
      clamp_c = 1'b0;
      shift_c = '0;
      exp_c   = '0;
      mant_c  = '0;
      pos2_c  = '0;
    end
  end

  // Stage 1 registers: encoded position, required shift and the carried operands.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_mant  <= '0;
      s1_exp   <= '0;
      s1_pos   <= '0;
      s1_req   <= '0;
      s1_zero  <= 1'b0;
    end else if (s1_adv_c) begin
      s1_valid <= in_fire_c;
      s1_mant  <= bus.mant_i;
      s1_exp   <= bus.exp_i;
      s1_pos   <= pos_c;
      s1_req   <= req_c;
      s1_zero  <= zero_c;
    end
  end

  // Stage 2 registers: every output is held while the downstream stalls.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bus.out_valid_o <= 1'b0;
      bus.mant_o      <= '0;
      bus.exp_o       <= '0;
      bus.pos_o       <= '0;
      bus.shift_o     <= '0;
      bus.zero_o      <= 1'b0;
      bus.unf_o       <= 1'b0;
    end else if (s2_adv_c) begin
      bus.out_valid_o <= s1_valid;
      bus.mant_o      <= mant_c;
      bus.exp_o       <= exp_c;
      bus.pos_o       <= pos2_c;
      bus.shift_o     <= shift_c;
      bus.zero_o      <= s1_zero;
      bus.unf_o       <= clamp_c;
    end
  end

endmodule

// File: doc/fp_lzd_normalizer.md
# fp_lzd_normalizer

Parametrised, pipelined leading-one detector and normalizer for the floating-point normalization path. It generalises the 4-to-2 MSB-priority encoder to a WIDTH-bit input and finds the highest set bit. It then left-shifts the mantissa so that bit becomes the MSB and adjusts the accompanying exponent, with clamping on exponent underflow. The block has two register stages with valid/ready handshakes on both sides, and sits between the adder/subtractor result stage and the rounding stage.

## Interface
- WIDTH, 24: mantissa width in bits; power of two not required; minimum 4.
- EXP_W, 8: exponent width in bits, unsigned biased.
- POS_W, $clog2(WIDTH): derived width of position and shift fields; not overridden.
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- in_valid_i  in  1  input word valid.
- in_ready_o  out  1  block can accept an input this cycle.
- mant_i  in  WIDTH  unnormalized mantissa.
- exp_i  in  EXP_W  exponent belonging to mant_i.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream accepts the result.
- mant_o  out  WIDTH  normalized mantissa.
- exp_o  out  EXP_W  adjusted exponent.
- pos_o  out  POS_W  index of the highest set bit of mant_i; 0 when mant_i is 0.
- shift_o  out  POS_W  left shift actually applied.
- zero_o  out  1  mant_i was all zeros.
- unf_o  out  1  the required shift exceeded exp_i and was clamped.

## Operation
- Transfer rules:
  - Input transfer: in_valid_i & in_ready_o at a rising edge.
  - Output transfer: out_valid_o & out_ready_i at a rising edge.
- Stage 1 (encode) registers:
  - pos = highest index i with mant_i[i]=1. This is MSB priority, matching the 4-to-2 encoder.
  - req = WIDTH-1-pos.
  - zero flag.
  - mant_i and exp_i, carried forward.
- Stage 2 (shift) registers all outputs:
  - If zero: mant_o=0, exp_o=0, pos_o=0, shift_o=0, zero_o=1, unf_o=0.
  - Else if req <= exp_i: shift_o=req, mant_o=mant_i<<req (mant_o[WIDTH-1]=1), exp_o=exp_i-req, unf_o=0.
  - Else (clamp): shift_o=exp_i, mant_o=mant_i<<exp_i, exp_o=0, unf_o=1. This is the denormal result.
  - exp_i=0 with a nonzero mantissa and req>0 gives shift_o=0, mant_o=mant_i, unf_o=1.
- Shifts fill with zeros on the LSB side. All arithmetic is unsigned and no wrap is possible, because the clamp guarantees exp_o >= 0.
- Pipeline control:
  - s2_adv = ~out_valid_o | out_ready_i.
  - s1_adv = ~s1_valid | s2_adv.
  - in_ready_o = s1_adv & ~rst_i.
  - in_ready_o combinationally depends on out_ready_i. There is no combinational path from in_valid_i to out_valid_o.
- Stage 2 loads from stage 1 when s2_adv is set. out_valid_o is then set to s1_valid.
- Stage 1 loads when s1_adv is set. s1_valid is then set to the input transfer condition.
- While out_valid_o=1 and out_ready_i=0, every output stays stable. No data is dropped or duplicated.

## Timing
- Reset, at a rising edge with rst_i=1:
  - s1_valid=0 and out_valid_o=0.
  - mant_o, exp_o, pos_o, shift_o, zero_o and unf_o all 0.
  - Stage-1 data registers cleared to 0.
  - in_ready_o=0 while rst_i=1.
- Reset mid-operation discards both stages. No output transfer occurs on the reset edge or after it.
- Latency: an input accepted at edge E appears on the outputs (out_valid_o=1) after edge E+1.
- Throughput is 1 word per cycle with out_ready_i held high.
- Full pipeline: both stages valid and out_ready_i=0 gives in_ready_o=0. Raising out_ready_i makes in_ready_o=1 in the same cycle, so drain and accept happen on the same edge.
- Empty pipeline: in_ready_o=1 regardless of out_ready_i.

## Test plan
- WIDTH=8, EXP_W=8: mant_i=0x13, exp_i=10 -> 2 edges later mant_o=0x98, exp_o=7, pos_o=4, shift_o=3, zero_o=0, unf_o=0.
- mant_i=0x80, exp_i=0 -> mant_o=0x80, exp_o=0, pos_o=7, shift_o=0, unf_o=0. Also mant_i=0x00, exp_i=55 -> all outputs 0 except zero_o=1.
- Clamp cases:
  - mant_i=0x01, exp_i=3 -> mant_o=0x08, exp_o=0, pos_o=0, shift_o=3, unf_o=1.
  - mant_i=0x01, exp_i=7 -> mant_o=0x80, exp_o=0, unf_o=0.
- Back-pressure: stream 0x01,0x02,0x04,0x08 (exp_i=20) with out_ready_i=0 for 5 cycles, then 1.
  - in_ready_o drops after 2 accepts; outputs hold stable.
  - Results arrive in order: exp_o=13,14,15,16, each mant_o=0x80. No loss or duplication.
- Assert rst_i for one cycle while two words are in flight -> out_valid_o=0 and all outputs 0 after the edge. in_ready_o=0 during reset and 1 the cycle after.
- Random regression on WIDTH=24 and WIDTH=5 with random valid/ready toggling, checked against a scoreboard model of the rules in Operation.
